// File: rtl/ivl_ovl_window_mc.sv
// ivl_ovl_window_mc
// -----------------------------------------------------------------------------
// Multi-channel window checker. Each channel opens a window on start_event and
// closes it on end_event. While the window is open, test_expr is checked
// either for level-high (CHECK_MODE=0) or for stability against the value
// captured at window open (CHECK_MODE=1). Optional minimum and maximum window
// lengths are also enforced. Violations pulse per-channel fire bits and are
// accumulated in a shared saturating 16-bit error counter.
//
// Parameters:
//   NUM_CH     - number of independent channels (1..32)
//   CNT_W      - width of the per-channel window-length counter
//   CHECK_MODE - 0: test_expr must be 1; 1: test_expr must equal its open value
//   MIN_WIN    - minimum window length in cycles, 0 disables
//   MAX_WIN    - maximum window length in cycles, 0 disables (< 2^CNT_W)
//
// Ports:
//   clock        - rising-edge clock
//   reset        - synchronous active-low reset
//   enable       - global check enable; when low, all state and err_count hold
//   start_event  - per-channel window open request
//   end_event    - per-channel window close request
//   test_expr    - per-channel checked expression
//   clear_count  - synchronous clear of err_count (same-cycle fires still count)
//   in_window    - channel is in the OPEN state (registered)
//   fire_expr    - one-cycle pulse on a test_expr violation
//   fire_short   - one-cycle pulse when a window closes below MIN_WIN
//   fire_timeout - one-cycle pulse when a window reaches MAX_WIN
//   err_count    - total violations across all channels, saturating
// -----------------------------------------------------------------------------
module ivl_ovl_window_mc #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int CHECK_MODE = 0,
    parameter int MIN_WIN    = 0,
    parameter int MAX_WIN    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] start_event,
    input  logic [NUM_CH-1:0] end_event,
    input  logic [NUM_CH-1:0] test_expr,
    input  logic              clear_count,
    output logic [NUM_CH-1:0] in_window,
    output logic [NUM_CH-1:0] fire_expr,
    output logic [NUM_CH-1:0] fire_short,
    output logic [NUM_CH-1:0] fire_timeout,
    output logic [15:0]       err_count
);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LEN_MAX = {CNT_W{1'b1}};
    localparam logic [31:0]      MIN_U   = MIN_WIN;
    localparam logic [31:0]      MAX_U   = MAX_WIN;

    state_t           state      [NUM_CH];
    logic [CNT_W-1:0] len        [NUM_CH];
    logic [NUM_CH-1:0] snap;

    state_t           state_n    [NUM_CH];
    logic [CNT_W-1:0] len_next   [NUM_CH];
    logic [CNT_W-1:0] len_inc    [NUM_CH];
    logic [NUM_CH-1:0] snap_n;
    logic [NUM_CH-1:0] expr_n;
    logic [NUM_CH-1:0] short_n;
    logic [NUM_CH-1:0] timeout_n;

    logic [6:0]       pop_n;
    logic [16:0]      sum_n;
    logic [15:0]      err_n;

    // Per-channel next-state logic. len_inc is the length the window will
    // have after this cycle, so comparing it against the bounds matches the
    // "start at edge k, end at edge k+n gives length n" definition. An end
    // request beats both a timeout and a concurrent start.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_n[i]   = state[i];
            len_next[i]  = len[i];
            len_inc[i]   = (len[i] == LEN_MAX) ? len[i] : len[i] + 1'b1;
            snap_n[i]    = snap[i];
            expr_n[i]    = 1'b0;
            short_n[i]   = 1'b0;
            timeout_n[i] = 1'b0;
            if (enable) begin
                case (state[i])
                    IDLE: begin
                        if (start_event[i]) begin
                            state_n[i]  = OPEN;
                            len_next[i] = '0;
                            snap_n[i]   = test_expr[i];
                        end
                    end
                    OPEN: begin
                        len_next[i] = len_inc[i];
                        if (CHECK_MODE == 0) begin
                            expr_n[i] = ~test_expr[i];
                        end else begin
                            expr_n[i] = test_expr[i] ^ snap[i];
                        end
                        if (end_event[i]) begin
                            state_n[i] = IDLE;
                            if ((MIN_WIN != 0) && (32'(len_inc[i]) < MIN_U)) begin
                                short_n[i] = 1'b1;
                            end
                        end else if ((MAX_WIN != 0) && (32'(len_inc[i]) == MAX_U)) begin
                            state_n[i]   = IDLE;
                            timeout_n[i] = 1'b1;
                        end
                    end
                    default: begin
                        state_n[i] = IDLE;
                    end
                endcase
            end
        end
    end

    // Count every fire bit that will be asserted next cycle, then add it to
    // the running total (or to zero on clear) with saturation at 16'hFFFF.
    always_comb begin
        pop_n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop_n = pop_n + 7'(expr_n[i]) + 7'(short_n[i]) + 7'(timeout_n[i]);
        end
        sum_n = (clear_count ? 17'd0 : {1'b0, err_count}) + 17'(pop_n);
        err_n = sum_n[16] ? 16'hFFFF : sum_n[15:0];
    end

    // Single register stage for FSMs, counters and all outputs. Reset wins
    // over everything, so a window in progress is dropped without firing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
                len[i]   <= '0;
            end
            snap         <= '0;
            in_window    <= '0;
            fire_expr    <= '0;
            fire_short   <= '0;
            fire_timeout <= '0;
            err_count    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]     <= state_n[i];
                len[i]       <= len_next[i];
                in_window[i] <= (state_n[i] == OPEN);
            end
            snap         <= snap_n;
            fire_expr    <= expr_n;
            fire_short   <= short_n;
            fire_timeout <= timeout_n;
            if (enable) begin
                err_count <= err_n;
            end
        end
    end

endmodule

// File: tb/tb_ivl_ovl_window_mc.sv
// tb_ivl_ovl_window_mc
// -----------------------------------------------------------------------------
// Directed testbench for ivl_ovl_window_mc. Two instances share clock, reset,
// enable and clear_count:
//   dut_a - level mode, MIN_WIN=3, MAX_WIN=5 (clean, level, bounds, collisions)
//   dut_b - stable mode, no bounds (stable check, counter saturation, reset)
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_ivl_ovl_window_mc;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       clear_count;

    logic [3:0] start_a, end_a, expr_a;
    logic [3:0] in_win_a, fx_a, fs_a, ft_a;
    logic [15:0] err_a;

    logic [3:0] start_b, end_b, expr_b;
    logic [3:0] in_win_b, fx_b, fs_b, ft_b;
    logic [15:0] err_b;

    int checks;
    int fails;

    ivl_ovl_window_mc #(
        .NUM_CH(4), .CNT_W(8), .CHECK_MODE(0), .MIN_WIN(3), .MAX_WIN(5)
    ) dut_a (
        .clock(clock), .reset(reset), .enable(enable),
        .start_event(start_a), .end_event(end_a), .test_expr(expr_a),
        .clear_count(clear_count),
        .in_window(in_win_a), .fire_expr(fx_a), .fire_short(fs_a),
        .fire_timeout(ft_a), .err_count(err_a)
    );

    ivl_ovl_window_mc #(
        .NUM_CH(4), .CNT_W(8), .CHECK_MODE(1), .MIN_WIN(0), .MAX_WIN(0)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(enable),
        .start_event(start_b), .end_event(end_b), .test_expr(expr_b),
        .clear_count(clear_count),
        .in_window(in_win_b), .fire_expr(fx_b), .fire_short(fs_b),
        .fire_timeout(ft_b), .err_count(err_b)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkA(input string tag, input logic [3:0] iw,
                          input logic [3:0] fx, input logic [3:0] fs,
                          input logic [3:0] ft, input logic [15:0] err);
        checkOutput({tag, " a.in_window"},    32'(in_win_a), 32'(iw));
        checkOutput({tag, " a.fire_expr"},    32'(fx_a),     32'(fx));
        checkOutput({tag, " a.fire_short"},   32'(fs_a),     32'(fs));
        checkOutput({tag, " a.fire_timeout"}, 32'(ft_a),     32'(ft));
        checkOutput({tag, " a.err_count"},    32'(err_a),    32'(err));
    endtask

    task automatic checkB(input string tag, input logic [3:0] iw,
                          input logic [3:0] fx, input logic [15:0] err);
        checkOutput({tag, " b.in_window"},    32'(in_win_b), 32'(iw));
        checkOutput({tag, " b.fire_expr"},    32'(fx_b),     32'(fx));
        checkOutput({tag, " b.fire_short"},   32'(fs_b),     32'h0);
        checkOutput({tag, " b.fire_timeout"}, 32'(ft_b),     32'h0);
        checkOutput({tag, " b.err_count"},    32'(err_b),    32'(err));
    endtask

    // Drive instance A inputs, then advance one edge and settle.
    task automatic applyStimulus(input logic [3:0] st, input logic [3:0] en,
                                 input logic [3:0] te);
        start_a = st;
        end_a   = en;
        expr_a  = te;
        @(posedge clock);
        #1;
    endtask

    // Drive instance B inputs, then advance one edge and settle.
    task automatic applyStimulusB(input logic [3:0] st, input logic [3:0] en,
                                  input logic [3:0] te);
        start_b = st;
        end_b   = en;
        expr_b  = te;
        @(posedge clock);
        #1;
    endtask

    // Directed sequence; expected values are worked out by hand per step.
    initial begin
        checks      = 0;
        fails       = 0;
        reset       = 1'b0;
        enable      = 1'b1;
        clear_count = 1'b0;
        start_a = 4'h0; end_a = 4'h0; expr_a = 4'hF;
        start_b = 4'h0; end_b = 4'h0; expr_b = 4'h0;

        // Reset state
        applyStimulus(4'h0, 4'h0, 4'hF);
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkA("reset", 4'h0, 4'h0, 4'h0, 4'h0, 16'd0);
        checkB("reset", 4'h0, 4'h0, 16'd0);
        reset = 1'b1;

        // Clean window on ch0, length 4
        applyStimulus(4'b0001, 4'h0, 4'hF);
        checkA("t1 open", 4'b0001, 4'h0, 4'h0, 4'h0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'h0, 4'h0, 4'hF);
            checkA("t1 mid", 4'b0001, 4'h0, 4'h0, 4'h0, 16'd0);
        end
        applyStimulus(4'h0, 4'b0001, 4'hF);
        checkA("t1 close", 4'h0, 4'h0, 4'h0, 4'h0, 16'd0);

        // Level violation on ch1, one low cycle, end at length 5 (= MAX)
        applyStimulus(4'b0010, 4'h0, 4'hF);
        checkA("t2 open", 4'b0010, 4'h0, 4'h0, 4'h0, 16'd0);
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkA("t2 ok", 4'b0010, 4'h0, 4'h0, 4'h0, 16'd0);
        applyStimulus(4'h0, 4'h0, 4'b1101);
        checkA("t2 fire", 4'b0010, 4'b0010, 4'h0, 4'h0, 16'd1);
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkA("t2 pulse", 4'b0010, 4'h0, 4'h0, 4'h0, 16'd1);
        applyStimulus(4'h0, 4'h0, 4'hF);
        applyStimulus(4'h0, 4'b0010, 4'hF);
        checkA("t2 end at max", 4'h0, 4'h0, 4'h0, 4'h0, 16'd1);

        // Short window on ch3, length 2
        applyStimulus(4'b1000, 4'h0, 4'hF);
        applyStimulus(4'h0, 4'h0, 4'hF);
        applyStimulus(4'h0, 4'b1000, 4'hF);
        checkA("t4 short", 4'h0, 4'h0, 4'b1000, 4'h0, 16'd2);
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkA("t4 short pulse", 4'h0, 4'h0, 4'h0, 4'h0, 16'd2);

        // Timeout on ch3 after 5 cycles with no end
        applyStimulus(4'b1000, 4'h0, 4'hF);
        checkA("t4 reopen", 4'b1000, 4'h0, 4'h0, 4'h0, 16'd2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h0, 4'h0, 4'hF);
            checkA("t4 waiting", 4'b1000, 4'h0, 4'h0, 4'h0, 16'd2);
        end
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkA("t4 timeout", 4'h0, 4'h0, 4'h0, 4'b1000, 16'd3);
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkA("t4 timeout pulse", 4'h0, 4'h0, 4'h0, 4'h0, 16'd3);

        // Expression and short fire together on ch2 (length 1, test low on end)
        applyStimulus(4'b0100, 4'h0, 4'hF);
        applyStimulus(4'h0, 4'b0100, 4'b1011);
        checkA("t5 expr+short", 4'h0, 4'b0100, 4'b0100, 4'h0, 16'd5);

        // Start+end while OPEN closes, no reopen (length 1 -> short)
        applyStimulus(4'b0001, 4'h0, 4'hF);
        applyStimulus(4'b0001, 4'b0001, 4'hF);
        checkA("t5 st+en open", 4'h0, 4'h0, 4'b0001, 4'h0, 16'd6);
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkA("t5 no reopen", 4'h0, 4'h0, 4'h0, 4'h0, 16'd6);

        // Start+end in IDLE opens; start while OPEN does not restart length
        applyStimulus(4'b0001, 4'b0001, 4'hF);
        checkA("t5 st+en idle", 4'b0001, 4'h0, 4'h0, 4'h0, 16'd6);
        applyStimulus(4'b0001, 4'h0, 4'hF);
        checkA("t5 start ignored", 4'b0001, 4'h0, 4'h0, 4'h0, 16'd6);
        applyStimulus(4'h0, 4'h0, 4'hF);
        applyStimulus(4'h0, 4'b0001, 4'hF);
        checkA("t5 close at min", 4'h0, 4'h0, 4'h0, 4'h0, 16'd6);

        // enable=0 across a violation and an end request
        applyStimulus(4'b0010, 4'h0, 4'hF);
        enable = 1'b0;
        applyStimulus(4'h0, 4'h0, 4'b1101);
        checkA("t5 disabled viol", 4'b0010, 4'h0, 4'h0, 4'h0, 16'd6);
        applyStimulus(4'h0, 4'b0010, 4'b1101);
        checkA("t5 disabled end", 4'b0010, 4'h0, 4'h0, 4'h0, 16'd6);
        enable = 1'b1;
        applyStimulus(4'h0, 4'h0, 4'hF);
        applyStimulus(4'h0, 4'h0, 4'hF);
        applyStimulus(4'h0, 4'b0010, 4'hF);
        checkA("t5 enabled close", 4'h0, 4'h0, 4'h0, 4'h0, 16'd6);

        // All four channels fire together with clear_count
        applyStimulus(4'hF, 4'h0, 4'hF);
        checkA("t5 all open", 4'hF, 4'h0, 4'h0, 4'h0, 16'd6);
        clear_count = 1'b1;
        applyStimulus(4'h0, 4'h0, 4'h0);
        clear_count = 1'b0;
        checkA("t5 clear+4", 4'hF, 4'hF, 4'h0, 4'h0, 16'd4);
        applyStimulus(4'h0, 4'hF, 4'hF);
        checkA("t5 4 short", 4'h0, 4'h0, 4'hF, 4'h0, 16'd8);
        clear_count = 1'b1;
        applyStimulus(4'h0, 4'h0, 4'hF);
        clear_count = 1'b0;
        checkA("t5 clear", 4'h0, 4'h0, 4'h0, 4'h0, 16'd0);

        // Stable mode on ch2 of B: snap 0, test high for two cycles
        applyStimulusB(4'b0100, 4'h0, 4'h0);
        checkB("t3 open", 4'b0100, 4'h0, 16'd0);
        applyStimulusB(4'h0, 4'h0, 4'h0);
        checkB("t3 stable", 4'b0100, 4'h0, 16'd0);
        applyStimulusB(4'h0, 4'h0, 4'b0100);
        checkB("t3 fire1", 4'b0100, 4'b0100, 16'd1);
        applyStimulusB(4'h0, 4'h0, 4'b0100);
        checkB("t3 fire2", 4'b0100, 4'b0100, 16'd2);
        applyStimulusB(4'h0, 4'h0, 4'h0);
        checkB("t3 back", 4'b0100, 4'h0, 16'd2);
        applyStimulusB(4'h0, 4'b0100, 4'h0);
        checkB("t3 close", 4'h0, 4'h0, 16'd2);

        // Saturation: 4 fires per cycle up to FFFC, then 2, then 3, then 4
        clear_count = 1'b1;
        applyStimulusB(4'h0, 4'h0, 4'h0);
        clear_count = 1'b0;
        checkB("t6 clear", 4'h0, 4'h0, 16'd0);
        applyStimulusB(4'hF, 4'h0, 4'h0);
        checkB("t6 open", 4'hF, 4'h0, 16'd0);
        for (int i = 0; i < 16383; i++) begin
            applyStimulusB(4'h0, 4'h0, 4'hF);
        end
        checkB("t6 preload", 4'hF, 4'hF, 16'hFFFC);
        applyStimulusB(4'h0, 4'h0, 4'b0011);
        checkB("t6 fffe", 4'hF, 4'b0011, 16'hFFFE);
        applyStimulusB(4'h0, 4'h0, 4'b0111);
        checkB("t6 saturate", 4'hF, 4'b0111, 16'hFFFF);
        applyStimulusB(4'h0, 4'h0, 4'hF);
        checkB("t6 hold sat", 4'hF, 4'hF, 16'hFFFF);

        // Reset mid-window aborts without fire
        reset = 1'b0;
        applyStimulusB(4'h0, 4'h0, 4'hF);
        checkB("t6 reset", 4'h0, 4'h0, 16'd0);
        checkA("t6 reset", 4'h0, 4'h0, 4'h0, 4'h0, 16'd0);
        reset = 1'b1;
        applyStimulusB(4'h0, 4'h0, 4'hF);
        checkB("t6 after reset", 4'h0, 4'h0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
